// File: rtl/spwm_carrier_compare.sv
`default_nettype none
// ============================================================================
// Module   : spwm_carrier_compare
// Purpose  : Sinusoidal-PWM modulator stage. Walks the index of an external
//            combinational half-wave sine table, samples its output once per
//            carrier period and compares that reference against a symmetric
//            triangular carrier. Produces complementary high/low gate drives
//            plus a half-wave polarity flag for the bridge steering logic.
// Macro    : SPWM_DEADTIME_EN - when defined, inserts DEAD_CYC cycles with
//            both gates low around every change of the compare result. When
//            undefined, the gates follow the compare result directly.
// Ports    : clk        in   system clock
//            rst_n      in   synchronous reset, active low
//            en         in   run enable; 0 freezes carrier/index, gates off
//            sine_out   in   table value for the current teth_ta (same cycle)
//            teth_ta    out  registered table index
//            half_neg   out  0 = positive half-wave, 1 = negative half-wave
//            pwm_hi     out  high-side gate
//            pwm_lo     out  low-side gate
//            cycle_tick out  one-cycle pulse at the end of each fundamental
// Revision : 1.0 - initial release
// ============================================================================
module spwm_carrier_compare #(
  parameter int CARRIER_MAX = 5000,
  parameter int IDX_MAX     = 88,
  parameter int CNT_W       = 13,
  parameter int IDX_W       = 10,
  parameter int DEAD_CYC    = 8,
  parameter int DT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] sine_out,
  output logic [IDX_W-1:0] teth_ta,
  output logic             half_neg,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             cycle_tick
);

  // Carrier slope direction; the carrier is a two-state up/down machine.
  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0] C_CNT_PEAK = CNT_W'(CARRIER_MAX);
  localparam logic [CNT_W-1:0] C_CNT_TURN = CNT_W'(CARRIER_MAX - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(IDX_MAX);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  // Dead-time reload must be representable and non-zero.
  localparam bit C_DT_CFG_OK = (DEAD_CYC >= 1) && (DEAD_CYC <= (1 << DT_W) - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             half_neg_q, half_neg_d;
  logic             raw_q, raw_d;
  logic             pwm_hi_q, pwm_hi_d;
  logic             pwm_lo_q, pwm_lo_d;
  logic             tick_q, tick_d;
  logic             valley;

  // --------------------------------------------------------------------------
  // Carrier, index, reference sample and compare
  // --------------------------------------------------------------------------
  always_comb begin
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    half_neg_d = half_neg_q;
    ref_d      = ref_q;
    tick_d     = 1'b0;
    valley     = 1'b0;

    if (en) begin
      case (dir_q)
        DIR_UP: begin
          if (cnt_q == C_CNT_TURN) begin
            cnt_d = C_CNT_PEAK;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        DIR_DOWN: begin
          if (cnt_q == C_CNT_ONE) begin
            cnt_d  = '0;
            dir_d  = DIR_UP;
            valley = 1'b1;
          end else begin
            cnt_d = cnt_q - C_CNT_ONE;
          end
        end
        default: begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end
      endcase

      // Advance the table once per carrier period, at the valley.
      if (valley) begin
        if (idx_q == C_IDX_LAST) begin
          idx_d      = '0;
          half_neg_d = ~half_neg_q;
          // Leaving the negative half closes one fundamental period.
          tick_d     = half_neg_q;
        end else begin
          idx_d = idx_q + C_IDX_ONE;
        end
      end

      // The index was updated on the previous edge, so the combinational
      // table output for it is stable by now.
      if ((dir_q == DIR_UP) && (cnt_q == '0)) begin
        ref_d = sine_out;
      end
    end

    raw_d = (ref_q > cnt_q);
  end

  // --------------------------------------------------------------------------
  // Gate drive
  // --------------------------------------------------------------------------
`ifdef SPWM_DEADTIME_EN
  localparam logic [DT_W-1:0] C_DT_LOAD = DT_W'(DEAD_CYC);
  localparam logic [DT_W-1:0] C_DT_ONE  = DT_W'(1);

  logic [DT_W-1:0] dt_q, dt_d;
  logic            raw_prev_q;

  // Both gates stay low while the counter runs. The count reaches zero on
  // the same edge that re-enables the gates, so exactly DEAD_CYC cycles
  // separate the falling gate from the rising one.
  always_comb begin
    pwm_hi_d = 1'b0;
    pwm_lo_d = 1'b0;
    dt_d     = dt_q;
    if (!en) begin
      dt_d = C_DT_LOAD;
    end else if (raw_q != raw_prev_q) begin
      dt_d = C_DT_LOAD;
    end else if (dt_q > C_DT_ONE) begin
      dt_d = dt_q - C_DT_ONE;
    end else begin
      dt_d     = '0;
      pwm_hi_d = raw_q;
      pwm_lo_d = ~raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dt_q       <= C_DT_LOAD;
      raw_prev_q <= 1'b0;
    end else begin
      dt_q       <= dt_d;
      raw_prev_q <= raw_q;
    end
  end
`else
  always_comb begin
    pwm_hi_d = 1'b0;
    pwm_lo_d = 1'b0;
    if (en) begin
      pwm_hi_d = raw_q;
      pwm_lo_d = ~raw_q;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q      <= DIR_UP;
      cnt_q      <= '0;
      idx_q      <= '0;
      half_neg_q <= 1'b0;
      ref_q      <= '0;
      raw_q      <= 1'b0;
      pwm_hi_q   <= 1'b0;
      pwm_lo_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      half_neg_q <= half_neg_d;
      ref_q      <= ref_d;
      raw_q      <= raw_d;
      pwm_hi_q   <= pwm_hi_d;
      pwm_lo_q   <= pwm_lo_d;
      tick_q     <= tick_d;
    end
  end

  assign teth_ta    = idx_q;
  assign half_neg   = half_neg_q;
  assign pwm_hi     = pwm_hi_q;
  assign pwm_lo     = pwm_lo_q;
  assign cycle_tick = tick_q;

  // Shoot-through guard: the two gates are never on together.
  a_no_overlap: assert property (@(posedge clk) !(pwm_hi_q && pwm_lo_q));
  a_dead_cfg:   assert property (@(posedge clk) C_DT_CFG_OK);

endmodule
`default_nettype wire

// File: tb/tb_spwm_carrier_compare.sv
`default_nettype none
// ============================================================================
// Module   : tb_spwm_carrier_compare
// Purpose  : Self-checking bench for spwm_carrier_compare with a scaled
//            carrier (CARRIER_MAX=40) and a behavioural 89-entry sine table.
//            A phase-based reference model pushes expected outputs to a queue
//            each cycle; they are popped and compared on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spwm_carrier_compare;

  localparam int CM    = 40;
  localparam int IMAX  = 88;
  localparam int CNT_W = 13;
  localparam int IDX_W = 10;
  localparam int DC    = 8;
  localparam int DTW   = 4;
  localparam int PER   = 2 * CM;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] sine_out;
  logic [IDX_W-1:0] teth_ta;
  logic             half_neg, pwm_hi, pwm_lo, cycle_tick;

  int lut [0:IMAX];

  always #5 clk = ~clk;

  spwm_carrier_compare #(
    .CARRIER_MAX(CM), .IDX_MAX(IMAX), .CNT_W(CNT_W), .IDX_W(IDX_W),
    .DEAD_CYC(DC), .DT_W(DTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sine_out(sine_out),
    .teth_ta(teth_ta), .half_neg(half_neg), .pwm_hi(pwm_hi),
    .pwm_lo(pwm_lo), .cycle_tick(cycle_tick)
  );

  // Behavioural sine table: half-wave, amplitude CM.
  always_comb begin
    sine_out = '0;
    if (int'(teth_ta) <= IMAX) sine_out = CNT_W'(lut[int'(teth_ta)]);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: carrier expressed as a phase 0..PER-1
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hn;
    logic             hi;
    logic             lo;
    logic             tk;
  } exp_t;

  exp_t sb_q[$];

  int m_ph, m_idx, m_ref, m_dt;
  bit m_hn, m_raw, m_rawp, m_hi, m_lo, m_tk;

  task automatic model_step(input bit r_n, input bit e);
    int   tri_v;
    bit   raw_n;
    exp_t ev;
    if (!r_n) begin
      m_ph = 0; m_idx = 0; m_ref = 0; m_dt = DC;
      m_hn = 0; m_raw = 0; m_rawp = 0; m_hi = 0; m_lo = 0; m_tk = 0;
    end else begin
      tri_v = (m_ph <= CM) ? m_ph : PER - m_ph;
      raw_n = (m_ref > tri_v);
`ifdef SPWM_DEADTIME_EN
      if (!e || (m_raw != m_rawp)) begin
        m_hi = 0; m_lo = 0; m_dt = DC;
      end else if (m_dt > 1) begin
        m_hi = 0; m_lo = 0; m_dt = m_dt - 1;
      end else begin
        m_dt = 0; m_hi = m_raw; m_lo = !m_raw;
      end
`else
      m_hi = e && m_raw;
      m_lo = e && !m_raw;
`endif
      m_tk = 0;
      if (e) begin
        if (m_ph == 0) m_ref = lut[m_idx];
        m_ph = (m_ph + 1) % PER;
        if (m_ph == 0) begin
          if (m_idx == IMAX) begin
            m_idx = 0;
            m_tk  = m_hn;
            m_hn  = !m_hn;
          end else begin
            m_idx = m_idx + 1;
          end
        end
      end
      m_rawp = m_raw;
      m_raw  = raw_n;
    end
    ev.idx = IDX_W'(m_idx);
    ev.hn  = m_hn;
    ev.hi  = m_hi;
    ev.lo  = m_lo;
    ev.tk  = m_tk;
    sb_q.push_back(ev);
  endtask

  // One clock: drive, predict, then compare after the active edge.
  task automatic step(input bit r_n, input bit e);
    exp_t ex;
    rst_n = r_n;
    en    = e;
    model_step(r_n, e);
    @(negedge clk);
    ex = sb_q.pop_front();
    chk("teth_ta",    int'(teth_ta),    int'(ex.idx));
    chk("half_neg",   int'(half_neg),   int'(ex.hn));
    chk("pwm_hi",     int'(pwm_hi),     int'(ex.hi));
    chk("pwm_lo",     int'(pwm_lo),     int'(ex.lo));
    chk("cycle_tick", int'(cycle_tick), int'(ex.tk));
    chk("overlap",    int'(pwm_hi & pwm_lo), 0);
  endtask

  int t_first1, t_hrise, t_tick, n_tick, hi0, lo0, hi44, reen_lat;

  initial begin
    for (int i = 0; i <= IMAX; i++)
      lut[i] = $rtoi(CM * $sin(3.14159265358979 * i / IMAX) + 0.5);

    // Reset with en high.
    repeat (3) step(1'b0, 1'b1);
    chk("rst_teth_ta", int'(teth_ta), 0);
    chk("rst_half_neg", int'(half_neg), 0);
    chk("rst_pwm_hi", int'(pwm_hi), 0);
    chk("rst_pwm_lo", int'(pwm_lo), 0);
    chk("rst_tick", int'(cycle_tick), 0);

    // One full fundamental period plus a little, en held high.
    t_first1 = -1; t_hrise = -1; t_tick = -1; n_tick = 0;
    hi0 = 0; lo0 = 0; hi44 = 0;
    for (int n = 1; n <= 2 * (IMAX + 1) * PER + 10; n++) begin
      step(1'b1, 1'b1);
      if (t_first1 < 0 && teth_ta == IDX_W'(1)) t_first1 = n;
      if (t_hrise < 0 && half_neg) t_hrise = n;
      if (cycle_tick) begin
        n_tick++;
        t_tick = n;
      end
      if (n == (IMAX + 1) * PER - 1) chk("idx_last", int'(teth_ta), IMAX);
      if (n == (IMAX + 1) * PER)     chk("idx_wrap", int'(teth_ta), 0);
      if (n >= 3 && n <= PER + 2) begin
        hi0 += int'(pwm_hi);
        lo0 += int'(pwm_lo);
      end
      if (n >= 44 * PER + 3 && n <= 45 * PER + 2) hi44 += int'(pwm_hi);
    end
    chk("first_step_cyc", t_first1, PER);
    chk("half_neg_rise_cyc", t_hrise, (IMAX + 1) * PER);
    chk("tick_count", n_tick, 1);
    chk("tick_cyc", t_tick, 2 * (IMAX + 1) * PER);
`ifndef SPWM_DEADTIME_EN
    chk("duty_idx0_hi", hi0, 0);
    chk("duty_idx0_lo", lo0, PER);
    chk("duty_idx44_hi", hi44, PER - 1);
`endif

    // Move to mid-slope, then freeze with en low.
    repeat (13) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("freeze_pwm_hi", int'(pwm_hi), 0);
    chk("freeze_pwm_lo", int'(pwm_lo), 0);
    repeat (11) step(1'b1, 1'b0);

    // Re-enable: count edges until a gate comes back on.
    reen_lat = -1;
    for (int n = 1; n <= 2 * PER; n++) begin
      step(1'b1, 1'b1);
      if (reen_lat < 0 && (pwm_hi || pwm_lo)) reen_lat = n;
    end
`ifdef SPWM_DEADTIME_EN
    chk("reenable_latency", reen_lat, DC);
`else
    chk("reenable_latency", reen_lat, 1);
`endif

    // Random enable pattern.
    for (int n = 0; n < 3000; n++) begin
      bit e_r;
      e_r = ($urandom_range(0, 3) != 0);
      step(1'b1, e_r);
`ifndef SPWM_DEADTIME_EN
      if (e_r) chk("complementary", int'(pwm_hi ^ pwm_lo), 1);
`endif
    end

    // Reset in the middle of operation.
    step(1'b0, 1'b1);
    chk("midrst_teth_ta", int'(teth_ta), 0);
    chk("midrst_half_neg", int'(half_neg), 0);
    chk("midrst_pwm_hi", int'(pwm_hi), 0);
    chk("midrst_pwm_lo", int'(pwm_lo), 0);
    repeat (3 * PER) step(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
